// File: rtl/hankel_pkg.sv
// Shared types and elaboration helpers for the Hankel sequence buffer.
package hankel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ANNOUNCE = 2'd1,
    ST_SERVE    = 2'd2
  } rd_state_t;

  function automatic int calc_depth(input int row, input int col);
    return row + col - 1;
  endfunction

  // Index width inside one bank; never zero so slices stay legal for tiny frames.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit addr_fits(input int addr_w, input int depth);
    return (64'(1) << addr_w) >= 64'(depth);
  endfunction

endpackage

// File: rtl/hsb_bank_ram.sv
// Two-bank sample RAM: one write port, one registered read port; bank is the address MSB.
module hsb_bank_ram
  import hankel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 7,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW:0]      waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             clr,
  input  logic [AW:0]      raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
  end

  // clr zeroes the output register so a rejected read returns 0.
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (re)  q <= mem[raddr[AW]][raddr[AW-1:0]];
    else if (clr) q <= '0;
  end

endmodule

// File: rtl/hankel_seq_buffer.sv
// Ping-pong frame buffer feeding the Hankel builder.
// Optional HSB_DROP_CNT_EN: in_ready tied high, overflow samples dropped and counted.
module hankel_seq_buffer
  import hankel_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ADDR  = 8,
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int DEPTH = calc_depth(ROW, COL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             start,
  input  logic             rd,
  input  logic [ADDR-1:0]  addr,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             err
`ifdef HSB_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int AW = idx_width(DEPTH);
  localparam logic [AW-1:0]  LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]  DEPTH_X   = (ADDR + 1)'(DEPTH);

  if (!addr_fits(ADDR, DEPTH)) begin : g_addr_check
    $error("hankel_seq_buffer: ADDR too narrow for DEPTH");
  end

  rd_state_t state, state_nxt;
  logic [1:0]    full, full_set, full_clr;
  logic          wbank, rbank;
  logic [AW-1:0] wptr;
  logic          accept, wr_last, rd_ok, rd_bad, rel, addr_in_range;

  // in_valid/in_ready: a sample moves on a rising edge where both are high.
`ifdef HSB_DROP_CNT_EN
  assign in_ready = 1'b1;
  assign accept   = in_valid && !full[wbank];
`else
  assign in_ready = !full[wbank];
  assign accept   = in_valid && in_ready;
`endif

  assign wr_last       = accept && (wptr == LAST_IDX);
  assign addr_in_range = {1'b0, addr} < DEPTH_X;
  assign full_set      = wr_last ? (2'b01 << wbank) : 2'b00;
  assign full_clr      = rel     ? (2'b01 << rbank) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (full[rbank]) state_nxt = ST_ANNOUNCE;
      ST_ANNOUNCE: state_nxt = ST_SERVE;
      ST_SERVE:    if (rel) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    rd_ok = 1'b0;
    rel   = 1'b0;
    unique case (state)
      ST_ANNOUNCE: start = 1'b1;
      ST_SERVE: begin
        rd_ok = rd && addr_in_range;
        rel   = rd && (addr == LAST_ADDR);
      end
      default: ;
    endcase
    rd_bad = rd && !rd_ok;
  end

  // Write and release touch different banks, so set/clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wptr  <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (accept) begin
        if (wr_last) begin
          wptr  <= '0;
          wbank <= ~wbank;
        end else begin
          wptr <= wptr + AW'(1);
        end
      end
      if (rel) begin
        rbank <= ~rbank;
        busy  <= 1'b0;
      end else if (state == ST_ANNOUNCE) begin
        busy <= 1'b1;
      end
      if (rd_bad) err <= 1'b1;
    end
  end

`ifdef HSB_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                              drop_cnt <= '0;
    else if (in_valid && full[wbank] && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  hsb_bank_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .waddr({wbank, wptr}),
    .wdata(in_data),
    .re   (rd_ok),
    .clr  (rd_bad),
    .raddr({rbank, addr[AW-1:0]}),
    .q    (data)
  );

endmodule

// File: tb/tb_hankel_seq_buffer.sv
// Directed bench for hankel_seq_buffer (default parameters, DEPTH=7).
module tb_hankel_seq_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        start;
  logic        rd;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        busy;
  logic        err;
`ifdef HSB_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  hankel_seq_buffer dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .start   (start),
    .rd      (rd),
    .addr    (addr),
    .data    (data),
    .busy    (busy),
    .err     (err)
`ifdef HSB_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rd = 1'b0; addr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Leaves in_valid high so consecutive pushes stream back to back.
  task automatic push(input logic [15:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL push_timeout: sample %0d never accepted", v);
    end
    tick();
  endtask

  task automatic rd_word(input logic [7:0] a);
    rd   = 1'b1;
    addr = a;
    tick();
    rd   = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (start !== 1'b0) $display("FAIL reset_start: got %b want 0", start); else pass_cnt++;
    total_cnt++; if (data !== 16'd0) $display("FAIL reset_data: got %0d want 0", data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
`ifdef HSB_DROP_CNT_EN
    total_cnt++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 7; i++) push(16'(i));
    in_valid = 1'b0;
    total_cnt++; if (start !== 1'b0) $display("FAIL fill_start_early: got %b want 0", start); else pass_cnt++;
    tick();
    total_cnt++; if (start !== 1'b1) $display("FAIL fill_start_pulse: got %b want 1", start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL fill_busy_announce: got %b want 0", busy); else pass_cnt++;
    tick();
    total_cnt++; if (start !== 1'b0) $display("FAIL fill_start_once: got %b want 0", start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL fill_busy_serve: got %b want 1", busy); else pass_cnt++;
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 1)) $display("FAIL fill_data a=%0d: got %0d want %0d", a, data, a + 1); else pass_cnt++;
      total_cnt++; if (busy !== (a < 6)) $display("FAIL fill_busy a=%0d: got %b want %b", a, busy, a < 6); else pass_cnt++;
    end
    total_cnt++; if (err !== 1'b0) $display("FAIL fill_err: got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_ping_pong();
    do_reset();
    for (int i = 1; i <= 13; i++) push(16'(i));
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL pp_ready_13: got %b want 1", in_ready); else pass_cnt++;
    push(16'd14);
    in_data = 16'd15;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL pp_ready_14: got %b want 0", in_ready); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL pp_ready_hold: got %b want 0", in_ready); else pass_cnt++;
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 1)) $display("FAIL pp_f1_data a=%0d: got %0d want %0d", a, data, a + 1); else pass_cnt++;
    end
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL pp_ready_rise: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (start !== 1'b0) $display("FAIL pp_start_early: got %b want 0", start); else pass_cnt++;
    tick();
    total_cnt++; if (start !== 1'b1) $display("FAIL pp_start2: got %b want 1", start); else pass_cnt++;
    for (int i = 16; i <= 21; i++) push(16'(i));
    in_valid = 1'b0;
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 8)) $display("FAIL pp_f2_data a=%0d: got %0d want %0d", a, data, a + 8); else pass_cnt++;
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL pp_busy_release: got %b want 0", busy); else pass_cnt++;
    tick();
    total_cnt++; if (start !== 1'b1) $display("FAIL pp_start3: got %b want 1", start); else pass_cnt++;
    tick();
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 15)) $display("FAIL pp_f3_data a=%0d: got %0d want %0d", a, data, a + 15); else pass_cnt++;
    end
  endtask

  task automatic test_boundary();
    do_reset();
    for (int i = 1; i <= 7; i++) push(16'(i));
    in_valid = 1'b0;
    tick();
    tick();
    rd_word(8'd2);
    total_cnt++; if (data !== 16'd3) $display("FAIL bnd_read2: got %0d want 3", data); else pass_cnt++;
    rd_word(8'd6);
    total_cnt++; if (data !== 16'd7) $display("FAIL bnd_read6: got %0d want 7", data); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL bnd_err_clean: got %b want 0", err); else pass_cnt++;
    rd_word(8'd0);
    total_cnt++; if (data !== 16'd0) $display("FAIL bnd_idle_data: got %0d want 0", data); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL bnd_idle_err: got %b want 1", err); else pass_cnt++;

    do_reset();
    for (int i = 1; i <= 7; i++) push(16'(i));
    in_valid = 1'b0;
    tick();
    tick();
    rd_word(8'd4);
    total_cnt++; if (data !== 16'd5) $display("FAIL bnd_read4: got %0d want 5", data); else pass_cnt++;
    rd_word(8'd7);
    total_cnt++; if (data !== 16'd0) $display("FAIL bnd_oob7_data: got %0d want 0", data); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL bnd_oob7_err: got %b want 1", err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL bnd_oob7_busy: got %b want 1", busy); else pass_cnt++;
    rd_word(8'd1);
    total_cnt++; if (data !== 16'd2) $display("FAIL bnd_read1: got %0d want 2", data); else pass_cnt++;
    rd_word(8'h81);
    total_cnt++; if (data !== 16'd0) $display("FAIL bnd_oob81_data: got %0d want 0", data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL bnd_oob81_busy: got %b want 1", busy); else pass_cnt++;
    rd_word(8'd6);
    total_cnt++; if (data !== 16'd7) $display("FAIL bnd_release: got %0d want 7", data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL bnd_busy_low: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int starts = 0;
    do_reset();
    for (int i = 50; i <= 53; i++) push(16'(i));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      if (start === 1'b1) starts++;
      tick();
    end
    for (int i = 100; i <= 102; i++) push(16'(i));
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (start === 1'b1) starts++;
      tick();
    end
    total_cnt++; if (starts !== 0) $display("FAIL rmid_no_start: got %0d pulses want 0", starts); else pass_cnt++;
    for (int i = 103; i <= 106; i++) push(16'(i));
    in_valid = 1'b0;
    tick();
    total_cnt++; if (start !== 1'b1) $display("FAIL rmid_start: got %b want 1", start); else pass_cnt++;
    tick();
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 100)) $display("FAIL rmid_data a=%0d: got %0d want %0d", a, data, a + 100); else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 1; i <= 13; i++) push(16'(i));
    in_valid = 1'b0;
    for (int a = 0; a < 6; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 1)) $display("FAIL sim_pre_data a=%0d: got %0d want %0d", a, data, a + 1); else pass_cnt++;
    end
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL sim_ready_pre: got %b want 1", in_ready); else pass_cnt++;
    in_valid = 1'b1;
    in_data  = 16'd14;
    rd       = 1'b1;
    addr     = 8'd6;
    tick();
    in_valid = 1'b0;
    rd       = 1'b0;
    total_cnt++; if (data !== 16'd7) $display("FAIL sim_rel_data: got %0d want 7", data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL sim_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL sim_ready_post: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (start !== 1'b0) $display("FAIL sim_start_early: got %b want 0", start); else pass_cnt++;
    tick();
    total_cnt++; if (start !== 1'b1) $display("FAIL sim_start: got %b want 1", start); else pass_cnt++;
    tick();
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 8)) $display("FAIL sim_b1_data a=%0d: got %0d want %0d", a, data, a + 8); else pass_cnt++;
    end
    tick();
    tick();
    total_cnt++; if (start !== 1'b0) $display("FAIL sim_no_extra_start: got %b want 0", start); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL sim_idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

`ifdef HSB_DROP_CNT_EN
  task automatic test_drop_cnt();
    int not_ready = 0;
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      in_data = 16'(i);
      if (in_ready !== 1'b1) not_ready++;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (not_ready !== 0) $display("FAIL drop_ready: low for %0d cycles want 0", not_ready); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 16'd16) $display("FAIL drop_cnt: got %0d want 16", drop_cnt); else pass_cnt++;
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 1)) $display("FAIL drop_f1 a=%0d: got %0d want %0d", a, data, a + 1); else pass_cnt++;
    end
    tick();
    total_cnt++; if (start !== 1'b1) $display("FAIL drop_start2: got %b want 1", start); else pass_cnt++;
    tick();
    for (int a = 0; a < 7; a++) begin
      rd_word(8'(a));
      total_cnt++; if (data !== 16'(a + 8)) $display("FAIL drop_f2 a=%0d: got %0d want %0d", a, data, a + 8); else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_ping_pong();
    test_boundary();
    test_reset_mid();
    test_simultaneous();
`ifdef HSB_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hankel_seq_buffer.md
Name: hankel_seq_buffer

Overview:
Upstream feeder for the Hankel matrix builder. Accepts a streamed scalar sequence on a valid/ready handshake and packs it into frames of DEPTH samples in a two-bank ping-pong RAM. Pulses start for each complete frame, then serves the builder's addr/rd reads with fixed one-cycle latency. A frame is released once its last sample has been read.

Parameters:
WIDTH, 16, sample width in bits
ADDR, 8, read-address width; 2**ADDR must be >= DEPTH
ROW, 4, Hankel rows of the downstream builder
COL, 4, Hankel columns of the downstream builder
DEPTH, ROW+COL-1, samples per frame (default 7)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_data  in  WIDTH  input sample
in_ready  out  1  buffer can accept in_data this cycle
start  out  1  one-cycle pulse: frame ready for the builder
rd  in  1  read strobe from the builder
addr  in  ADDR  frame-relative read address
data  out  WIDTH  read data, registered
busy  out  1  a frame is presented to the builder and not yet released
err  out  1  sticky: out-of-range address, or read while not busy
drop_cnt  out  16  dropped-sample count; present only with HSB_DROP_CNT_EN

Behaviour:
- Reset values: in_ready=1, start=0, data=0, busy=0, err=0, drop_cnt=0. Both banks empty; wbank=0, rbank=0, wptr=0.
- Reset mid-operation discards all frames: partial and full banks, and any in-progress read.
- Write side:
  - Sample accepted when in_valid && in_ready; written to bank[wbank][wptr], then wptr increments.
  - When wptr==DEPTH-1 is accepted: set full[wbank], wptr<=0, toggle wbank.
  - in_ready = !full[wbank].
- Read-side FSM: IDLE, ANNOUNCE, SERVE.
  - IDLE: if full[rbank], go to ANNOUNCE.
  - ANNOUNCE: start=1 for exactly this cycle; busy<=1; go to SERVE.
  - SERVE: on rd with addr<DEPTH, data<=bank[rbank][addr] on the next edge (latency 1); data holds its value when rd=0.
  - SERVE: rd with addr>=DEPTH gives data<=0 and err<=1.
  - SERVE release: a read of addr==DEPTH-1 clears full[rbank], toggles rbank, sets busy<=0 and returns to IDLE. The data for that read is still returned the following cycle.
  - rd in IDLE or ANNOUNCE: data<=0, err<=1.
  - Reads may repeat and may arrive in any order. The builder reads addr 0..COL-1, then COL..DEPTH-1, in order.
- Minimum turnaround: if the next bank is already full at release, start re-asserts 2 cycles after the releasing read (IDLE->ANNOUNCE).
- Simultaneous events:
  - Write completion into bank X in the same cycle as release of bank Y: both take effect; full bits update independently.
  - A bank released this cycle is writable next cycle; in_ready rises one cycle after release.
  - Writer and reader never address the same bank concurrently; full[] gates both.
- err is cleared only by rst.

Optional Feature:
HSB_DROP_CNT_EN
- Defined:
  - in_ready is tied to 1.
  - A sample arriving while full[wbank] is discarded, and drop_cnt increments, saturating at 16'hFFFF.
  - The drop_cnt port exists.
- Undefined:
  - Backpressure as above; no sample is ever lost.
  - drop_cnt port and logic are absent.

Decomposition:
- Package hankel_pkg: read-FSM state encoding (IDLE, ANNOUNCE, SERVE); DEPTH derivation function; a parameter check that 2**ADDR >= DEPTH.
- One sub-module hsb_bank_ram:
  - single-write, single-read, registered-read RAM of 2*DEPTH x WIDTH;
  - bank select is the MSB of the RAM address.

Test Plan:
- Fill, default params: stream 1..7 with in_valid held -> start pulses once, 2 cycles after the 7th accept; reads addr 0..6 return 1..7 with 1-cycle latency; busy falls after the addr 6 read.
- Ping-pong backpressure: stream 1..21 continuously with no reads -> in_ready drops after sample 14. Reading frame 1 (addr 0..6) releases bank 0; in_ready rises next cycle; second start pulses 2 cycles after the release read; reads return 8..14.
- Boundary read: in SERVE, rd with addr=7 -> data=0, err=1, busy stays 1; rd addr=0 while IDLE -> err=1, data=0.
- Reset mid-frame: accept 4 samples, assert rst for 1 cycle -> no start; then stream 100..106 -> start pulses; reads return 100..106.
- Simultaneous: complete the write of bank 1 in the same cycle as the addr 6 read of bank 0 -> both full flags correct; start for bank 1 follows 2 cycles later.
- HSB_DROP_CNT_EN: stream 30 samples with no reads -> in_ready constantly 1, drop_cnt=16, frames hold 1..7 and 8..14.
